// File: rtl/mem_stage_ctrl.sv
// Byte-serial MEM-stage controller: splits byte/halfword/word loads and stores
// into big-endian single-byte cycles on an 8-bit RAM and stalls the pipeline meanwhile.
module mem_stage_ctrl (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        Mem_Enable,
    input  logic        Mem_RW,
    input  logic [1:0]  Mem_Size,
    input  logic        Load_Signed,
    input  logic [31:0] Addr,
    input  logic [31:0] Data_In,
    output logic [31:0] Data_Out,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  base_reg;
    logic [31:0] data_reg;
    logic [31:0] sh_reg;
    logic [31:0] data_out_reg;
    logic [1:0]  size_reg;
    logic [1:0]  idx_reg;
    logic        rw_reg;
    logic        signed_reg;
    logic        err_reg;

    logic        legal;
    logic [1:0]  last_idx;
    logic [1:0]  byte_sel;
    logic        last_byte;
    logic [31:0] sh_next;
    logic [31:0] load_word;
    logic [7:0]  data_bytes [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign data_bytes[gi] = data_reg[gi*8 +: 8];
    end

    always_comb begin
        legal = 1'b0;
        case (Mem_Size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~Addr[0];
            2'b10:   legal = (Addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        last_idx = 2'd3;
        case (size_reg)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    assign last_byte = (idx_reg == last_idx);
    // Most significant byte of the right-justified store data goes out first.
    assign byte_sel  = last_idx - idx_reg;
    assign sh_next   = {sh_reg[23:0], ram_rdata};

    always_comb begin
        load_word = sh_next;
        case (size_reg)
            2'b00:   load_word = {{24{signed_reg & sh_next[7]}}, sh_next[7:0]};
            2'b01:   load_word = {{16{signed_reg & sh_next[15]}}, sh_next[15:0]};
            default: load_word = sh_next;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Mem_Enable) state_next = legal ? XFER : DONE;
            XFER:    if (last_byte) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            base_reg     <= '0;
            data_reg     <= '0;
            sh_reg       <= '0;
            data_out_reg <= '0;
            size_reg     <= '0;
            idx_reg      <= '0;
            rw_reg       <= 1'b0;
            signed_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (Mem_Enable) begin
                    base_reg   <= Addr[7:0];
                    data_reg   <= Data_In;
                    size_reg   <= Mem_Size;
                    rw_reg     <= Mem_RW;
                    signed_reg <= Load_Signed;
                    err_reg    <= ~legal;
                    idx_reg    <= 2'd0;
                end
                XFER: begin
                    if (!rw_reg) sh_reg <= sh_next;
                    // Result is registered with the final byte so it is visible during DONE.
                    if (last_byte) begin
                        if (!rw_reg) data_out_reg <= load_word;
                    end else begin
                        idx_reg <= idx_reg + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Data_Out  = data_out_reg;
    assign Busy      = ~CLR & (((state_reg == IDLE) & Mem_Enable) | (state_reg == XFER));
    assign Done      = (state_reg == DONE);
    assign Err       = (state_reg == DONE) & err_reg;
    assign ram_we    = (state_reg == XFER) & rw_reg & ~CLR;
    assign ram_addr  = (state_reg == XFER) ? (base_reg + {6'd0, idx_reg}) : 8'd0;
    assign ram_wdata = ((state_reg == XFER) && rw_reg) ? data_bytes[byte_sel] : 8'd0;

endmodule
